tri_wire_sequencer: RTL and testbench

//  Wireframe triangle front-end for the Bresenham line drawer (draw_line).
//  - Accepts one screen-space triangle (3 vertices) over a valid/ready handshake.
//  - Clamps the vertices to the screen.
//  - Optionally culls back-facing or degenerate triangles by signed area.
//  - Otherwise drives draw_line three times: V0->V1, V1->V2, V2->V0.

---
 rtl/tri_wire_sequencer.sv | 147 ++++++++++++++
 tb/tb_tri_wire_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_wire_sequencer.sv
// Wireframe triangle front-end: clamps a triangle to the screen, optionally culls it
// by signed area, and sequences its three edges through the draw_line handshake.
module tri_wire_sequencer #(
    parameter int COORD_W = 10,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [COORD_W-1:0] v0_x,
    input  logic [COORD_W-1:0] v0_y,
    input  logic [COORD_W-1:0] v1_x,
    input  logic [COORD_W-1:0] v1_y,
    input  logic [COORD_W-1:0] v2_x,
    input  logic [COORD_W-1:0] v2_y,
    input  logic               cull_en,
    output logic [COORD_W-1:0] line_x0,
    output logic [COORD_W-1:0] line_y0,
    output logic [COORD_W-1:0] line_x1,
    output logic [COORD_W-1:0] line_y1,
    output logic               line_start,
    input  logic               line_done,
    output logic [1:0]         edge_idx,
    output logic               busy,
    output logic               tri_done,
    output logic               tri_culled
);

    localparam logic [COORD_W:0]   H_LIM = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0]   V_LIM = (COORD_W+1)'(V_RES);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SETUP, S_RUN, S_RELEASE, S_FINISH
    } state_t;

    state_t state, next_state;
    logic [1:0] edge_q, edge_d;
    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
    logic cull_q, culled_q, cull_hit;

    logic signed [COORD_W:0]     dx1, dy1, dx2, dy2;
    logic signed [2*COORD_W+1:0] p1, p2;
    logic signed [2*COORD_W+2:0] area;
    logic [COORD_W-1:0] sx0, sy0, sx1, sy1;

    function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v,
                                                 input logic [COORD_W:0]   lim,
                                                 input logic [COORD_W-1:0] mx);
        return ({1'b0, v} >= lim) ? mx : v;
    endfunction

    always_comb begin
        dx1  = $signed({1'b0, x1_q}) - $signed({1'b0, x0_q});
        dy1  = $signed({1'b0, y1_q}) - $signed({1'b0, y0_q});
        dx2  = $signed({1'b0, x2_q}) - $signed({1'b0, x0_q});
        dy2  = $signed({1'b0, y2_q}) - $signed({1'b0, y0_q});
        p1   = (2*COORD_W+2)'(dx1) * (2*COORD_W+2)'(dy2);
        p2   = (2*COORD_W+2)'(dx2) * (2*COORD_W+2)'(dy1);
        area = {p1[2*COORD_W+1], p1} - {p2[2*COORD_W+1], p2};
        cull_hit = cull_q && (area[2*COORD_W+2] || (area == '0));
    end

    always_comb begin
        next_state = state;
        edge_d     = edge_q;
        unique case (state)
            S_IDLE:    if (tri_valid) next_state = S_CHECK;
            S_CHECK: begin
                edge_d     = 2'd0;
                next_state = cull_hit ? S_FINISH : S_SETUP;
            end
            S_SETUP:   next_state = S_RUN;
            S_RUN:     if (line_done) next_state = S_RELEASE;
            S_RELEASE: begin
                if (!line_done) begin
                    if (edge_q == 2'd2) begin
                        next_state = S_FINISH;
                    end else begin
                        edge_d     = edge_q + 2'd1;
                        next_state = S_SETUP;
                    end
                end
            end
            S_FINISH: begin
                edge_d     = 2'd0;
                next_state = S_IDLE;
            end
            default:   next_state = S_IDLE;
        endcase
    end

    // Endpoints are chosen from the edge being entered so they settle during SETUP.
    always_comb begin
        sx0 = x2_q; sy0 = y2_q; sx1 = x0_q; sy1 = y0_q;
        case (edge_d)
            2'd0:    begin sx0 = x0_q; sy0 = y0_q; sx1 = x1_q; sy1 = y1_q; end
            2'd1:    begin sx0 = x1_q; sy0 = y1_q; sx1 = x2_q; sy1 = y2_q; end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            edge_q     <= '0;
            line_start <= 1'b0;
            line_x0    <= '0;
            line_y0    <= '0;
            line_x1    <= '0;
            line_y1    <= '0;
            culled_q   <= 1'b0;
            cull_q     <= 1'b0;
            x0_q <= '0; y0_q <= '0; x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0;
        end else begin
            state      <= next_state;
            edge_q     <= edge_d;
            line_start <= (next_state == S_RUN);
            if (state == S_IDLE && tri_valid) begin
                x0_q   <= clamp(v0_x, H_LIM, X_MAX);
                y0_q   <= clamp(v0_y, V_LIM, Y_MAX);
                x1_q   <= clamp(v1_x, H_LIM, X_MAX);
                y1_q   <= clamp(v1_y, V_LIM, Y_MAX);
                x2_q   <= clamp(v2_x, H_LIM, X_MAX);
                y2_q   <= clamp(v2_y, V_LIM, Y_MAX);
                cull_q <= cull_en;
            end
            if (state == S_CHECK) culled_q <= cull_hit;
            if (next_state == S_SETUP) begin
                line_x0 <= sx0;
                line_y0 <= sy0;
                line_x1 <= sx1;
                line_y1 <= sy1;
            end
        end
    end

    assign tri_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign tri_done   = (state == S_FINISH);
    assign tri_culled = (state == S_FINISH) && culled_q;
    assign edge_idx   = edge_q;

endmodule

// File: tb/tb_tri_wire_sequencer.sv
// Scoreboard bench for tri_wire_sequencer with a behavioural draw_line responder.
module tb_tri_wire_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       tri_valid, tri_ready, cull_en;
    logic [9:0] v0_x, v0_y, v1_x, v1_y, v2_x, v2_y;
    logic [9:0] line_x0, line_y0, line_x1, line_y1;
    logic       line_start, line_done;
    logic [1:0] edge_idx;
    logic       busy, tri_done, tri_culled;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int e, x0, y0, x1, y1;
    } seg_t;
    seg_t seg_q[$];
    bit   cul_q[$];

    tri_wire_sequencer #(.COORD_W(10), .H_RES(640), .V_RES(480)) dut (
        .Clk(Clk), .Reset(Reset), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .v0_x(v0_x), .v0_y(v0_y), .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
        .cull_en(cull_en),
        .line_x0(line_x0), .line_y0(line_y0), .line_x1(line_x1), .line_y1(line_y1),
        .line_start(line_start), .line_done(line_done), .edge_idx(edge_idx),
        .busy(busy), .tri_done(tri_done), .tri_culled(tri_culled)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int clx(input int v);
        return (v >= 640) ? 639 : v;
    endfunction

    function automatic int cly(input int v);
        return (v >= 480) ? 479 : v;
    endfunction

    task automatic push_expect(input int ax, ay, bx, by, cx, cy, input bit ce);
        int px[3];
        int py[3];
        int area;
        seg_t s;
        px[0] = clx(ax); py[0] = cly(ay);
        px[1] = clx(bx); py[1] = cly(by);
        px[2] = clx(cx); py[2] = cly(cy);
        area = (px[1] - px[0]) * (py[2] - py[0]) - (px[2] - px[0]) * (py[1] - py[0]);
        if (ce && area <= 0) begin
            cul_q.push_back(1'b1);
        end else begin
            for (int e = 0; e < 3; e++) begin
                s.e  = e;
                s.x0 = px[e];           s.y0 = py[e];
                s.x1 = px[(e + 1) % 3]; s.y1 = py[(e + 1) % 3];
                seg_q.push_back(s);
            end
            cul_q.push_back(1'b0);
        end
    endtask

    // Returns just after the accepting edge; with hold=1 tri_valid stays asserted.
    task automatic send_tri(input int ax, ay, bx, by, cx, cy, input bit ce, input bit hold);
        int n;
        v0_x = 10'(ax); v0_y = 10'(ay);
        v1_x = 10'(bx); v1_y = 10'(by);
        v2_x = 10'(cx); v2_y = 10'(cy);
        cull_en   = ce;
        tri_valid = 1'b1;
        n = 0;
        while (!tri_ready && n < 5000) begin
            @(negedge Clk);
            n++;
        end
        check("accept_wait", 64'(tri_ready), 64'd1);
        push_expect(ax, ay, bx, by, cx, cy, ce);
        @(posedge Clk);
        #1;
        if (!hold) begin
            tri_valid = 1'b0;
            v0_x = 10'($urandom_range(0, 1023)); v1_y = 10'($urandom_range(0, 1023));
            cull_en = ~ce;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge Clk);
        while (busy && n < 5000) begin
            @(negedge Clk);
            n++;
        end
        check("idle_wait", 64'(busy), 64'd0);
        @(negedge Clk);
    endtask

    // draw_line stand-in: random draw time, done held until line_start drops.
    initial begin
        int dl;
        line_done = 1'b0;
        dl = -1;
        forever begin
            @(negedge Clk);
            if (!line_start) begin
                line_done = 1'b0;
                dl = -1;
            end else if (!line_done) begin
                if (dl < 0)       dl = int'($urandom_range(0, 6));
                else if (dl == 0) line_done = 1'b1;
                else              dl--;
            end
        end
    end

    bit          prev_ls;
    int          gap;
    logic [39:0] held;

    always @(negedge Clk) begin
        seg_t s;
        bit   c;
        if (Reset) begin
            prev_ls = 1'b0;
            gap     = 100;
        end else begin
            if (line_start && !prev_ls) begin
                check("low_gap", 64'(gap >= 2), 64'd1);
                check("seg_pending", 64'(seg_q.size() != 0), 64'd1);
                if (seg_q.size() != 0) begin
                    s = seg_q.pop_front();
                    check("edge_idx", 64'(edge_idx), 64'(s.e));
                    check("line_x0", 64'(line_x0), 64'(s.x0));
                    check("line_y0", 64'(line_y0), 64'(s.y0));
                    check("line_x1", 64'(line_x1), 64'(s.x1));
                    check("line_y1", 64'(line_y1), 64'(s.y1));
                end
                held = {line_x0, line_y0, line_x1, line_y1};
            end else if (line_start) begin
                check("ep_hold", 64'({line_x0, line_y0, line_x1, line_y1}), 64'(held));
            end
            if (line_start) begin
                check("rdy_run", 64'(tri_ready), 64'd0);
                check("busy_run", 64'(busy), 64'd1);
            end
            gap = line_start ? 0 : gap + 1;
            if (tri_done) begin
                check("done_pending", 64'(cul_q.size() != 0), 64'd1);
                if (cul_q.size() != 0) begin
                    c = cul_q.pop_front();
                    check("tri_culled", 64'(tri_culled), 64'(c));
                end
            end
            prev_ls = line_start;
        end
    end

    initial begin
        int n;
        Reset = 1'b1; tri_valid = 1'b0; cull_en = 1'b0;
        v0_x = '0; v0_y = '0; v1_x = '0; v1_y = '0; v2_x = '0; v2_y = '0;
        repeat (3) @(negedge Clk);
        check("rst_start", 64'(line_start), 64'd0);
        check("rst_done", 64'(tri_done), 64'd0);
        check("rst_culled", 64'(tri_culled), 64'd0);
        check("rst_edge", 64'(edge_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(tri_ready), 64'd1);
        check("rst_ep", 64'({line_x0, line_y0, line_x1, line_y1}), 64'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // front-facing triangle, with first-line latency
        send_tri(10, 10, 100, 10, 10, 80, 1'b1, 1'b0);
        repeat (2) @(negedge Clk);
        check("lat_pre_start", 64'(line_start), 64'd0);
        @(negedge Clk);
        check("lat_start", 64'(line_start), 64'd1);
        wait_idle();

        // back-facing triangle, culled with done latency
        send_tri(10, 10, 10, 80, 100, 10, 1'b1, 1'b0);
        @(negedge Clk);
        check("lat_pre_done", 64'(tri_done), 64'd0);
        @(negedge Clk);
        check("lat_done", 64'(tri_done), 64'd1);
        wait_idle();

        // off-screen vertex clamps
        send_tri(10, 10, 700, 500, 200, 300, 1'b0, 1'b0);
        wait_idle();

        // degenerate triangle: drawn without culling, culled with it
        send_tri(50, 50, 50, 50, 50, 50, 1'b0, 1'b0);
        wait_idle();
        send_tri(50, 50, 50, 50, 50, 50, 1'b1, 1'b0);
        wait_idle();

        // back-to-back with tri_valid held; inputs change while busy
        for (int k = 0; k < 5; k++) begin
            send_tri(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                     int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                     int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                     1'($urandom_range(0, 1)), 1'b1);
        end
        tri_valid = 1'b0;
        wait_idle();

        // reset during edge 1 aborts without tri_done
        send_tri(20, 30, 300, 40, 150, 200, 1'b0, 1'b0);
        n = 0;
        while (!(line_start && edge_idx == 2'd1) && n < 5000) begin
            @(negedge Clk);
            n++;
        end
        check("reach_edge1", 64'(line_start && edge_idx == 2'd1), 64'd1);
        Reset = 1'b1;
        seg_q.delete();
        cul_q.delete();
        @(negedge Clk);
        check("abort_start", 64'(line_start), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(tri_ready), 64'd1);
        check("abort_edge", 64'(edge_idx), 64'd0);
        Reset = 1'b0;
        repeat (40) @(negedge Clk);

        check("seg_left", 64'(seg_q.size()), 64'd0);
        check("cul_left", 64'(cul_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
